// File: rtl/vga_pkg.sv
// Shared mode encodings, bar colours and 640x480@60 timing defaults for the
// VGA test-pattern generator.
package vga_pkg;

  typedef enum logic [1:0] {
    ModeBars    = 2'd0,
    ModeChecker = 2'd1,
    ModeBox     = 2'd2,
    ModeGrad    = 2'd3
  } mode_e;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FP_DEF     = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BP_DEF     = 48;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FP_DEF     = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 33;

  localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
  localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
  localparam logic [15:0] RGB_CYAN    = 16'h07FF;
  localparam logic [15:0] RGB_GREEN   = 16'h07E0;
  localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
  localparam logic [15:0] RGB_RED     = 16'hF800;
  localparam logic [15:0] RGB_BLUE    = 16'h001F;
  localparam logic [15:0] RGB_BLACK   = 16'h0000;

  function automatic logic [15:0] bar_rgb(input logic [2:0] idx);
    logic [15:0] c;
    unique case (idx)
      3'd0: c = RGB_WHITE;
      3'd1: c = RGB_YELLOW;
      3'd2: c = RGB_CYAN;
      3'd3: c = RGB_GREEN;
      3'd4: c = RGB_MAGENTA;
      3'd5: c = RGB_RED;
      3'd6: c = RGB_BLUE;
      3'd7: c = RGB_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchroniser plus counting debouncer; btn_rise pulses together with
// the debounced level going high.
module button_debounce #(
  parameter int unsigned DEB_CYC = 500000
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_rise
);

  localparam int unsigned CW = $clog2(DEB_CYC + 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          rise_q, rise_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    level_d = level_q;
    rise_d  = 1'b0;
    cnt_d   = '0;
    // Count consecutive samples that disagree with the accepted level.
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(DEB_CYC - 1)) begin
        level_d = sync2_q;
        rise_d  = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_in;
      sync2_q <= sync1_q;
      level_q <= level_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign btn_level = level_q;
  assign btn_rise  = rise_q;

endmodule

// File: rtl/vga_pattern_gen.sv
// VGA timing plus four selectable test patterns; the pattern only changes on a
// frame boundary so a frame never mixes two modes.
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned DEB_CYC  = 500000,
  parameter int unsigned BOX      = 32,
  parameter int unsigned CHK_LOG2 = 5
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        button,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [15:0] rgb,
  output logic [1:0]  mode,
  output logic        frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);
  localparam int unsigned BAR_W   = H_ACTIVE / 8;
  localparam int unsigned BW      = (BAR_W > 1) ? $clog2(BAR_W) : 1;
  localparam int unsigned MAX_X   = H_ACTIVE - BOX;
  localparam int unsigned MAX_Y   = V_ACTIVE - BOX;

  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic [BW-1:0] bar_px_q, bar_px_d;
  logic [2:0]    bar_idx_q, bar_idx_d;
  logic [1:0]    pend_q, pend_d;
  mode_e         mode_q, mode_d;
  logic [HW-1:0] box_x_q, box_x_d, nxt_x_q, nxt_x_d;
  logic [VW-1:0] box_y_q, box_y_d, nxt_y_q, nxt_y_d;
  logic          dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic          hsync_q, vsync_q, de_q, fs_q;
  logic [15:0]   rgb_q;

  logic          h_wrap, v_wrap, frame_edge, active, in_box;
  logic          btn_level, btn_rise, press;
  logic          hs_d, vs_d;
  logic [15:0]   pix, rgb_d;
  logic [31:0]   hx, vy, bx, by;

  button_debounce #(
    .DEB_CYC (DEB_CYC)
  ) u_debounce (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .btn_in    (button),
    .btn_level (btn_level),
    .btn_rise  (btn_rise)
  );

  assign press = btn_rise & btn_level;
  assign hx    = 32'(h_cnt_q);
  assign vy    = 32'(v_cnt_q);

  always_comb begin
    h_wrap     = h_cnt_q == HW'(H_TOTAL - 1);
    v_wrap     = v_cnt_q == VW'(V_TOTAL - 1);
    frame_edge = (h_cnt_q == '0) && (v_cnt_q == '0);
    h_cnt_d    = h_wrap ? '0 : h_cnt_q + 1'b1;
    v_cnt_d    = v_cnt_q;
    if (h_wrap) v_cnt_d = v_wrap ? '0 : v_cnt_q + 1'b1;

    // Bar index tracks h_cnt with a small counter instead of dividing by BAR_W.
    bar_px_d  = bar_px_q + 1'b1;
    bar_idx_d = bar_idx_q;
    if (h_wrap) begin
      bar_px_d  = '0;
      bar_idx_d = '0;
    end else if (bar_px_q == BW'(BAR_W - 1)) begin
      bar_px_d  = '0;
      bar_idx_d = bar_idx_q + 1'b1;
    end

    mode_d = frame_edge ? mode_e'(pend_q) : mode_q;
    pend_d = pend_q + {1'b0, press};
  end

  // nxt_* is the position for the coming frame; it is shown from pixel (0,0) on.
  always_comb begin
    nxt_x_d = nxt_x_q;
    dir_x_d = dir_x_q;
    nxt_y_d = nxt_y_q;
    dir_y_d = dir_y_q;
    if (frame_edge && (MAX_X != 0)) begin
      if (dir_x_q) begin
        if (nxt_x_q == HW'(MAX_X)) begin
          dir_x_d = 1'b0;
          nxt_x_d = nxt_x_q - 1'b1;
        end else begin
          nxt_x_d = nxt_x_q + 1'b1;
        end
      end else if (nxt_x_q == '0) begin
        dir_x_d = 1'b1;
        nxt_x_d = nxt_x_q + 1'b1;
      end else begin
        nxt_x_d = nxt_x_q - 1'b1;
      end
    end
    if (frame_edge && (MAX_Y != 0)) begin
      if (dir_y_q) begin
        if (nxt_y_q == VW'(MAX_Y)) begin
          dir_y_d = 1'b0;
          nxt_y_d = nxt_y_q - 1'b1;
        end else begin
          nxt_y_d = nxt_y_q + 1'b1;
        end
      end else if (nxt_y_q == '0) begin
        dir_y_d = 1'b1;
        nxt_y_d = nxt_y_q + 1'b1;
      end else begin
        nxt_y_d = nxt_y_q - 1'b1;
      end
    end
    box_x_d = frame_edge ? nxt_x_q : box_x_q;
    box_y_d = frame_edge ? nxt_y_q : box_y_q;
  end

  always_comb begin
    bx     = 32'(box_x_d);
    by     = 32'(box_y_d);
    active = (hx < H_ACTIVE) && (vy < V_ACTIVE);
    in_box = (hx >= bx) && (hx < bx + BOX) && (vy >= by) && (vy < by + BOX);
    hs_d   = ((hx >= H_ACTIVE + H_FP) && (hx < H_ACTIVE + H_FP + H_SYNC)) ? HS_POL : ~HS_POL;
    vs_d   = ((vy >= V_ACTIVE + V_FP) && (vy < V_ACTIVE + V_FP + V_SYNC)) ? VS_POL : ~VS_POL;
    pix    = RGB_BLACK;
    unique case (mode_d)
      ModeBars:    pix = bar_rgb(bar_idx_q);
      ModeChecker: pix = (hx[CHK_LOG2] ^ vy[CHK_LOG2]) ? RGB_BLACK : RGB_WHITE;
      ModeBox:     pix = in_box ? RGB_RED : RGB_BLUE;
      ModeGrad:    pix = {hx[4:0], vy[5:0], hx[4:0]};
    endcase
    rgb_d = active ? pix : RGB_BLACK;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      h_cnt_q   <= '0;
      v_cnt_q   <= '0;
      bar_px_q  <= '0;
      bar_idx_q <= '0;
      pend_q    <= '0;
      mode_q    <= ModeBars;
      box_x_q   <= '0;
      box_y_q   <= '0;
      nxt_x_q   <= '0;
      nxt_y_q   <= '0;
      dir_x_q   <= 1'b1;
      dir_y_q   <= 1'b1;
      hsync_q   <= ~HS_POL;
      vsync_q   <= ~VS_POL;
      de_q      <= 1'b0;
      rgb_q     <= '0;
      fs_q      <= 1'b0;
    end else begin
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      bar_px_q  <= bar_px_d;
      bar_idx_q <= bar_idx_d;
      pend_q    <= pend_d;
      mode_q    <= mode_d;
      box_x_q   <= box_x_d;
      box_y_q   <= box_y_d;
      nxt_x_q   <= nxt_x_d;
      nxt_y_q   <= nxt_y_d;
      dir_x_q   <= dir_x_d;
      dir_y_q   <= dir_y_d;
      hsync_q   <= hs_d;
      vsync_q   <= vs_d;
      de_q      <= active;
      rgb_q     <= rgb_d;
      fs_q      <= frame_edge;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign rgb         = rgb_q;
  assign mode        = mode_q;
  assign frame_start = fs_q;

endmodule

// File: doc/vga_pattern_gen.md
VGA_PATTERN_GEN -- requirements
Module: vga_pattern_gen

Interface
REQ-001 Parameters SHALL be, one per line, name, default, meaning:
  H_ACTIVE 640 visible pixels/line (multiple of 8); H_FP 16; H_SYNC 96; H_BP 48
  V_ACTIVE 480 visible lines; V_FP 10; V_SYNC 2; V_BP 33
  HS_POL 0, VS_POL 0: sync active level (0 = active-low)
  DEB_CYC 500000: stable cycles required to accept a button change
  BOX 32: moving-box side in pixels; CHK_LOG2 5: checker cell = 2^CHK_LOG2 px
REQ-002 Ports SHALL be, one per line, name, direction, width, meaning:
  sys_clk  in  1  single clock, all logic rising-edge
  sys_rst  in  1  synchronous, active-high reset
  button   in  1  raw asynchronous push-button, 1 = pressed
  hsync    out 1  horizontal sync, polarity HS_POL
  vsync    out 1  vertical sync, polarity VS_POL
  de       out 1  1 while the pixel is in the active area
  rgb      out 16 RGB565 pixel, 0 outside the active area
  mode     out 2  currently displayed pattern
  frame_start out 1  one-cycle pulse with the first pixel (0,0)

Function
REQ-003 h_cnt SHALL count 0..H_TOTAL-1 (H_TOTAL = sum of the H_* values), wrapping to 0; v_cnt SHALL advance only on the h_cnt wrap, counting 0..V_TOTAL-1 and wrapping.
REQ-004 Active area: h_cnt<H_ACTIVE and v_cnt<V_ACTIVE; hsync asserted for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC; vsync uses the same rule with V_* values, evaluated per line.
REQ-005 All outputs SHALL be registered, with exactly 1 cycle of latency from the counter value they encode; hsync, vsync, de and rgb SHALL stay mutually aligned.
REQ-006 frame_start SHALL be 1 for exactly one cycle per frame, aligned with pixel (0,0).
REQ-007 Mode 0, colour bars: eight bars of H_ACTIVE/8 px, left to right FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000; bar index from a per-line bar counter, no divider.
REQ-008 Mode 1, checkerboard: FFFF when x[CHK_LOG2] XOR y[CHK_LOG2] = 0, else 0000.
REQ-009 Mode 2, moving box: F800 inside the BOX x BOX square at (box_x, box_y), else 001F.
REQ-010 Mode 3, gradient: rgb = {x[4:0], y[5:0], x[4:0]}.
REQ-011 Box position SHALL update once per frame, on the frame_start cycle, by +-1 in x and in y; an axis reverses direction when the step would place the box beyond 0 or H_ACTIVE-BOX (V_ACTIVE-BOX), and the box SHALL never leave the active area.
REQ-012 Button path: 2-flop synchroniser, then debouncer; the stable state changes only after DEB_CYC consecutive equal samples, and a shorter glitch SHALL be ignored.
REQ-013 Each debounced 0->1 edge SHALL increment pending_mode modulo 4 (3->0); a held button SHALL produce exactly one increment.
REQ-014 mode SHALL load pending_mode only at frame_start, so no frame mixes two patterns; several presses within one frame SHALL accumulate.
REQ-015 A press edge coinciding with frame_start SHALL apply the pre-increment value now and the increment at the next frame.

Reset
REQ-016 On sys_rst, in the same clock edge: h_cnt=v_cnt=0; hsync=~HS_POL, vsync=~VS_POL; de=0, rgb=0, frame_start=0; mode=pending_mode=0; box at (0,0) moving +x,+y; synchroniser and debouncer cleared to "released".
REQ-017 Reset asserted mid-frame SHALL abort the frame; the first frame_start SHALL occur 1 cycle after reset deasserts.

Structure
REQ-018 Shared package vga_pkg SHALL hold the mode encodings, the eight RGB565 bar constants, and the 640x480@60 timing defaults.
REQ-019 The debouncer SHALL be a sub-module button_debounce (parameter DEB_CYC; ports sys_clk, sys_rst, btn_in, btn_level, btn_rise).

Verification (small timing: H 8/2/2/2, V 4/1/1/1, DEB_CYC 4, BOX 2, CHK_LOG2 1)
REQ-020 After reset, sample one full frame -> H_TOTAL=14, V_TOTAL=7; hsync low at h_cnt 10-11; vsync low on line 5; de high for 32 cycles per frame; frame_start once per 98 cycles.
REQ-021 Mode 0, line 0 -> rgb sequence FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000, then 0000 with de=0 for 6 cycles.
REQ-022 Button high for 3 cycles -> mode unchanged; held 10 cycles -> mode becomes 1 at the next frame_start, not earlier.
REQ-023 Mode 2 over 8 frames -> box_x runs 0,1,2,3,4,5,6,5 (reverses at 6); box_y runs 0,1,2,1,0,1,2,1.
REQ-024 sys_rst asserted at h_cnt=5, v_cnt=2 in mode 3 -> next cycle all outputs at REQ-016 values; frame_start one cycle after release.
REQ-025 Four debounced presses within one frame -> mode wraps 0->0 at next frame_start; pending_mode sequence 1,2,3,0.
